// File: rtl/param_fifo_pkg.sv
// Shared defaults and sizing helpers for param_fifo.
package param_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 96;
    localparam int unsigned DEF_DEPTH      = 4;

    // One extra MSB beyond the address lets full and empty be told apart.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DEPTH x DATA_WIDTH register storage for param_fifo.
// It has one write port and one asynchronous read port, and it resets to zero.
module fifo_regfile
    import param_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    localparam int unsigned AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_fifo.sv
// Synchronous show-ahead FIFO with occupancy-derived status flags.
// Define PARAM_FIFO_ERR_FLAGS_EN to build the sticky overflow and underflow flags.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned DEPTH      = DEF_DEPTH,
    parameter  int unsigned AF_LEVEL   = DEPTH - 1,
    parameter  int unsigned AE_LEVEL   = 1,
    localparam int unsigned PW         = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  w_enable,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  r_enable,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PW-1:0]         count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          push_acc;
    logic          pop_acc;

    // Status is derived purely from the registered pointers.
    always_comb begin
        empty        = (wptr_q == rptr_q);
        full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        count        = wptr_q - rptr_q;
        almost_full  = (32'(count) >= AF_LEVEL);
        almost_empty = (32'(count) <= AE_LEVEL);
    end

    assign push_acc = w_enable && !full && !clear;
    assign pop_acc  = r_enable && !empty && !clear;

    always_comb begin
        wptr_d = wptr_q + PW'(push_acc);
        rptr_d = rptr_q + PW'(pop_acc);
        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    fifo_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .n_rst   (n_rst),
        .we_i    (push_acc),
        .waddr_i (wptr_q[AW-1:0]),
        .wdata_i (w_data),
        .raddr_i (rptr_q[AW-1:0]),
        .rdata_o (r_data)
    );

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    // A dropped push still flags overflow, even when a pop is accepted on the same edge.
    always_comb begin
        ovf_d = ovf_q || (w_enable && full);
        unf_d = unf_q || (r_enable && empty);
        if (clear) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed self-checking bench for param_fifo (DATA_WIDTH=96, DEPTH=4).
module tb_param_fifo;

`ifdef PARAM_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        n_rst;
    logic        clear;
    logic        w_enable;
    logic [95:0] w_data;
    logic        r_enable;
    logic [95:0] r_data;
    logic        empty, full, almost_full, almost_empty;
    logic [2:0]  count;
    logic        overflow, underflow;

    int n_cmp = 0;
    int n_err = 0;

    param_fifo dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .w_enable     (w_enable),
        .w_data       (w_data),
        .r_enable     (r_enable),
        .r_data       (r_data),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_enable = 1'b0;
        r_enable = 1'b0;
        clear    = 1'b0;
        w_data   = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        n_rst = 1'b0;
        #12;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_af got %b exp 0", almost_full); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (r_data !== 96'd0) begin n_err++; $display("FAIL reset_rdata got %h exp 0", r_data); end
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL reset_err got %b exp 00", {overflow, underflow}); end
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [95:0] pat;
        pat = {12{8'hA5}};
        w_enable = 1'b1; w_data = pat;
        step();
        idle_inputs();
        step();
        n_cmp++; if (r_data !== pat) begin n_err++; $display("FAIL single_rdata got %h exp %h", r_data, pat); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", count); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty got %b exp 0", empty); end
        r_enable = 1'b1;
        step();
        idle_inputs();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_pop_empty got %b exp 1", empty); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 4; i++) begin
            w_enable = 1'b1; w_data = 96'(i);
            step();
            n_cmp++; if (count !== 3'(i)) begin n_err++; $display("FAIL fill_count%0d got %0d exp %0d", i, count, i); end
            n_cmp++; if (almost_full !== (i >= 3)) begin n_err++; $display("FAIL fill_af%0d got %b exp %b", i, almost_full, (i >= 3)); end
            n_cmp++; if (full !== (i == 4)) begin n_err++; $display("FAIL fill_full%0d got %b exp %b", i, full, (i == 4)); end
        end
        w_data = 96'd5;
        step();
        idle_inputs();
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_drop_count got %0d exp 4", count); end
        n_cmp++; if (overflow !== ERR_EN) begin n_err++; $display("FAIL fill_overflow got %b exp %b", overflow, ERR_EN); end
        for (int i = 1; i <= 4; i++) begin
            n_cmp++; if (r_data !== 96'(i)) begin n_err++; $display("FAIL fill_pop%0d got %0d exp %0d", i, r_data, i); end
            r_enable = 1'b1;
            step();
        end
        idle_inputs();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fill_final_empty got %b exp 1", empty); end
        do_clear();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL fill_clear_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_stream();
        w_enable = 1'b1; w_data = 96'd100;
        step();
        w_data = 96'd101;
        step();
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (r_data !== 96'(100 + i)) begin n_err++; $display("FAIL stream_head%0d got %0d exp %0d", i, r_data, 100 + i); end
            w_enable = 1'b1; r_enable = 1'b1; w_data = 96'(102 + i);
            step();
            n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL stream_count%0d got %0d exp 2", i, count); end
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (r_data !== 96'(110 + i)) begin n_err++; $display("FAIL stream_tail%0d got %0d exp %0d", i, r_data, 110 + i); end
            r_enable = 1'b1;
            step();
        end
        idle_inputs();
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL stream_empty got %b exp 1", empty); end
    endtask

    task automatic test_simultaneous();
        do_clear();
        w_enable = 1'b1; r_enable = 1'b1; w_data = 96'h55;
        step();
        idle_inputs();
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL sim_empty_count got %0d exp 1", count); end
        n_cmp++; if (r_data !== 96'h55) begin n_err++; $display("FAIL sim_empty_rdata got %h exp 55", r_data); end
        n_cmp++; if (underflow !== ERR_EN) begin n_err++; $display("FAIL sim_underflow got %b exp %b", underflow, ERR_EN); end
        for (int i = 0; i < 3; i++) begin
            w_enable = 1'b1; w_data = 96'(96'h60 + 96'(i));
            step();
        end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL sim_full got %b exp 1", full); end
        w_enable = 1'b1; r_enable = 1'b1; w_data = 96'h77;
        step();
        idle_inputs();
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL sim_full_count got %0d exp 3", count); end
        n_cmp++; if (r_data !== 96'h60) begin n_err++; $display("FAIL sim_full_head got %h exp 60", r_data); end
        // Clear wins over a concurrent push.
        w_enable = 1'b1; clear = 1'b1; w_data = 96'h88;
        step();
        idle_inputs();
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL sim_clear_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL sim_clear_empty got %b exp 1", empty); end
    endtask

    task automatic test_err_flags();
        r_enable = 1'b1;
        step();
        idle_inputs();
        step();
        n_cmp++; if (underflow !== ERR_EN) begin n_err++; $display("FAIL err_unf_held got %b exp %b", underflow, ERR_EN); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL err_ovf_idle got %b exp 0", overflow); end
        for (int i = 0; i < 5; i++) begin
            w_enable = 1'b1; w_data = 96'(i);
            step();
        end
        idle_inputs();
        n_cmp++; if (overflow !== ERR_EN) begin n_err++; $display("FAIL err_ovf got %b exp %b", overflow, ERR_EN); end
        do_clear();
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_err++; $display("FAIL err_clear got %b exp 00", {overflow, underflow}); end
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL err_clear_count got %0d exp 0", count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            w_enable = 1'b1; w_data = 96'(96'h30 + 96'(i));
            step();
        end
        w_data = 96'h99;
        #2;
        n_rst = 1'b0;
        #1;
        n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL arst_count got %0d exp 0", count); end
        n_cmp++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin n_err++; $display("FAIL arst_flags got %b%b exp 11", empty, almost_empty); end
        n_cmp++; if (r_data !== 96'd0) begin n_err++; $display("FAIL arst_rdata got %h exp 0", r_data); end
        idle_inputs();
        #4;
        n_rst = 1'b1;
        step();
        w_enable = 1'b1; w_data = 96'd7;
        step();
        idle_inputs();
        n_cmp++; if (r_data !== 96'd7) begin n_err++; $display("FAIL arst_push got %0d exp 7", r_data); end
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL arst_push_count got %0d exp 1", count); end
        n_cmp++; if (dut.u_regfile.mem_q[0] !== 96'd7) begin n_err++; $display("FAIL arst_entry0 got %0d exp 7", dut.u_regfile.mem_q[0]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_simultaneous();
        test_err_flags();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
